mult_entry_ctrl: RTL and testbench

- Sequences operand entry and result display for the 2-bit binary multiplier and the 7-segment decoder on the FPGA calculator board.
- Captures operand A, then operand B, from two slide switches using a debounced ENTER push-button.
- Drives the multiplier's A/B inputs from registered operands, latches the 4-bit product, and selects what the seg decoder shows. Pushing decimal 15 into the decoder blanks the display.

---
 rtl/mult_entry_ctrl_pkg.sv | 23 ++
 rtl/mult_entry_ctrl_if.sv | 32 +++
 rtl/mult_entry_ctrl_debounce.sv | 71 +++++++
 rtl/mult_entry_ctrl.sv | 137 +++++++++++++
 tb/tb_mult_entry_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mult_entry_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mult_calc_pkg : shared types and constants for the calculator entry sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mult_calc_pkg;

   localparam int OP_W   = 2;
   localparam int PROD_W = 4;

   localparam logic [PROD_W-1:0] DISP_BLANK = 4'd15;

   typedef enum logic [1:0] {
      GET_A = 2'b00,
      GET_B = 2'b01,
      CALC  = 2'b10,
      SHOW  = 2'b11
   } state_t;

endpackage

`default_nettype wire

// File: rtl/mult_entry_ctrl_if.sv
// ----------------------------------------------------------------------------
// mult_entry_ctrl_if : board-side switches/buttons, multiplier and display bus
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mult_entry_ctrl_if
   import mult_calc_pkg::*;
;
   logic [OP_W-1:0]   sw;
   logic              btn_enter;
   logic              btn_clr;
   logic [OP_W-1:0]   mult_a;
   logic [OP_W-1:0]   mult_b;
   logic [PROD_W-1:0] mult_c;
   logic [PROD_W-1:0] disp_num;
   logic [1:0]        state_led;

   // master is the board/multiplier side, slave is the sequencer
   modport master (
      output sw, btn_enter, btn_clr, mult_c,
      input  mult_a, mult_b, disp_num, state_led
   );

   modport slave (
      input  sw, btn_enter, btn_clr, mult_c,
      output mult_a, mult_b, disp_num, state_led
   );

endinterface

`default_nettype wire

// File: rtl/mult_entry_ctrl_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce : 2-flop sync, stable-count debounce and rising-edge pulse
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic btn_i,
   output logic      pulse_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q;
   logic [1:0]       prime_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             armed_q, armed_d;
   logic             pulse_q, pulse_d;
   logic             btn_s;

   assign btn_s = sync_q[1];

   // A pulse needs the input to have been seen low after reset, so a button
   // held through reset release must be released before it can fire.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      pulse_d = 1'b0;
      armed_d = armed_q | (prime_q[1] & ~btn_s);
      if (btn_s != level_q) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = btn_s;
            pulse_d = btn_s & armed_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= 2'b00;
         prime_q <= 2'b00;
         cnt_q   <= '0;
         level_q <= 1'b0;
         armed_q <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], btn_i};
         prime_q <= {prime_q[0], 1'b1};
         cnt_q   <= cnt_d;
         level_q <= level_d;
         armed_q <= armed_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse_o = pulse_q;

endmodule

`default_nettype wire

// File: rtl/mult_entry_ctrl.sv
// ----------------------------------------------------------------------------
// mult_entry_ctrl : operand entry / product display sequencer; optional entry
// blink under MEC_BLINK_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mult_entry_ctrl
   import mult_calc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int BLINK_HALF      = 12500000
) (
   input wire logic          clk,
   input wire logic          rst_n,
   mult_entry_ctrl_if.slave  bus
);

   if (DEBOUNCE_CYCLES < 2 || BLINK_HALF < 1) begin : g_param_check
      $error("mult_entry_ctrl: DEBOUNCE_CYCLES must be >= 2 and BLINK_HALF >= 1");
   end

   logic [OP_W-1:0]   sw_meta_q, sw_s_q;
   logic              enter_p, clr_p;
   state_t            state_q, state_d;
   logic [OP_W-1:0]   mult_a_q, mult_a_d, mult_b_q, mult_b_d;
   logic [PROD_W-1:0] prod_q, prod_d, disp_q, disp_d;
   logic              blank_entry;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
      .clk(clk), .rst_n(rst_n), .btn_i(bus.btn_enter), .pulse_o(enter_p)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
      .clk(clk), .rst_n(rst_n), .btn_i(bus.btn_clr), .pulse_o(clr_p)
   );

   always_comb begin
      state_d  = state_q;
      mult_a_d = mult_a_q;
      mult_b_d = mult_b_q;
      prod_d   = prod_q;
      disp_d   = blank_entry ? DISP_BLANK : {{(PROD_W-OP_W){1'b0}}, sw_s_q};
      case (state_q)
         GET_A: if (enter_p) begin
            mult_a_d = sw_s_q;
            state_d  = GET_B;
         end
         GET_B: if (enter_p) begin
            mult_b_d = sw_s_q;
            state_d  = CALC;
         end
         CALC: begin
            prod_d  = bus.mult_c;
            disp_d  = DISP_BLANK;
            state_d = SHOW;
         end
         SHOW: begin
            disp_d = prod_q;
            if (enter_p) state_d = GET_A;
         end
         default: state_d = GET_A;
      endcase
      // clear overrides any enter seen in the same cycle
      if (clr_p) begin
         state_d  = GET_A;
         mult_a_d = '0;
         mult_b_d = '0;
         prod_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_meta_q <= '0;
         sw_s_q    <= '0;
         state_q   <= GET_A;
         mult_a_q  <= '0;
         mult_b_q  <= '0;
         prod_q    <= '0;
         disp_q    <= '0;
      end else begin
         sw_meta_q <= bus.sw;
         sw_s_q    <= sw_meta_q;
         state_q   <= state_d;
         mult_a_q  <= mult_a_d;
         mult_b_q  <= mult_b_d;
         prod_q    <= prod_d;
         disp_q    <= disp_d;
      end
   end

`ifdef MEC_BLINK_EN
   localparam int BLK_W = $clog2(BLINK_HALF + 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);

   logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic             blink_off_q, blink_off_d;

   always_comb begin
      blink_cnt_d = blink_cnt_q;
      blink_off_d = blink_off_q;
      if (state_d != state_q) begin
         blink_cnt_d = '0;
         blink_off_d = 1'b0;
      end else if (state_q == GET_A || state_q == GET_B) begin
         if (blink_cnt_q == BLK_LAST) begin
            blink_cnt_d = '0;
            blink_off_d = ~blink_off_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt_q <= '0;
         blink_off_q <= 1'b0;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         blink_off_q <= blink_off_d;
      end
   end

   assign blank_entry = blink_off_q;
`else
   assign blank_entry = 1'b0;
`endif

   assign bus.mult_a    = mult_a_q;
   assign bus.mult_b    = mult_b_q;
   assign bus.disp_num  = disp_q;
   assign bus.state_led = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_entry_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mult_entry_ctrl : randomized bench with a sample-history reference model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mult_entry_ctrl;

   localparam int DB = 4;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   mult_entry_ctrl_if bus ();

   mult_entry_ctrl #(.DEBOUNCE_CYCLES(DB), .BLINK_HALF(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // the multiplier itself lives outside the block
   assign bus.mult_c = bus.mult_a * bus.mult_b;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: raw input history per clock edge, debounced levels
   // judged from a window of the last DB synchronized samples.
   int q_sw[$], q_en[$], q_cl[$];
   int h_en[$], h_cl[$];
   int lv_en, lv_cl, arm_en, arm_cl, p_en, p_cl;
   int m_state, m_a, m_b, m_prod, m_disp;

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".state"},  int'(bus.state_led), m_state);
      check({tag, ".mult_a"}, int'(bus.mult_a),    m_a);
      check({tag, ".mult_b"}, int'(bus.mult_b),    m_b);
      check({tag, ".disp"},   int'(bus.disp_num),  m_disp);
   endtask

   task automatic model_reset();
      q_sw.delete(); q_en.delete(); q_cl.delete();
      h_en.delete(); h_cl.delete();
      lv_en = 0; lv_cl = 0; arm_en = 0; arm_cl = 0; p_en = 0; p_cl = 0;
      m_state = 0; m_a = 0; m_b = 0; m_prod = 0; m_disp = 0;
   endtask

   function automatic bit all_differ(input int win[$], input int lvl);
      if (win.size() < DB) return 1'b0;
      foreach (win[i]) if (win[i] == lvl) return 1'b0;
      return 1'b1;
   endfunction

   // advance the model across one rising edge with the given raw inputs
   task automatic model_step(input int s, input int e, input int c);
      int  s_sw, s_en, s_cl, nd, np_en, np_cl;
      bit  real_s;
      q_sw.push_back(s); q_en.push_back(e); q_cl.push_back(c);
      if (q_sw.size() > 3) begin
         void'(q_sw.pop_front()); void'(q_en.pop_front()); void'(q_cl.pop_front());
      end
      real_s = (q_sw.size() == 3);
      s_sw = real_s ? q_sw[0] : 0;
      s_en = real_s ? q_en[0] : 0;
      s_cl = real_s ? q_cl[0] : 0;

      nd = (m_state <= 1) ? s_sw : ((m_state == 2) ? 15 : m_prod);
      if (p_cl != 0) begin
         m_state = 0; m_a = 0; m_b = 0; m_prod = 0;
      end else begin
         case (m_state)
            0: if (p_en != 0) begin m_a = s_sw; m_state = 1; end
            1: if (p_en != 0) begin m_b = s_sw; m_state = 2; end
            2: begin m_prod = m_a * m_b; m_state = 3; end
            default: if (p_en != 0) m_state = 0;
         endcase
      end
      m_disp = nd;

      h_en.push_back(s_en); if (h_en.size() > DB) void'(h_en.pop_front());
      h_cl.push_back(s_cl); if (h_cl.size() > DB) void'(h_cl.pop_front());
      np_en = 0; np_cl = 0;
      if (all_differ(h_en, lv_en)) begin lv_en = 1 - lv_en; np_en = lv_en & arm_en; end
      if (all_differ(h_cl, lv_cl)) begin lv_cl = 1 - lv_cl; np_cl = lv_cl & arm_cl; end
      if (real_s && s_en == 0) arm_en = 1;
      if (real_s && s_cl == 0) arm_cl = 1;
      p_en = np_en; p_cl = np_cl;
   endtask

   // called at a falling edge: drive, cross one rising edge, compare
   task automatic cycle(input int s, input int e, input int c);
      bus.sw        = 2'(s);
      bus.btn_enter = (e != 0);
      bus.btn_clr   = (c != 0);
      model_step(s, e, c);
      @(negedge clk);
      check_all("cyc");
   endtask

   task automatic hold(input int s, input int e, input int c, input int n);
      for (int i = 0; i < n; i++) cycle(s, e, c);
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_all("rst_async");
      repeat (3) @(negedge clk);
      check_all("rst_hold");
      rst_n = 1'b1;
   endtask

   int seg_len, seg_sw, seg_en, seg_cl;

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      bus.sw = 2'd3; bus.btn_enter = 1'b0; bus.btn_clr = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check("reset.state", int'(bus.state_led), 0);
      check("reset.disp",  int'(bus.disp_num),  0);
      check_all("reset");
      rst_n = 1'b1;

      // operands 3 and 3
      hold(3, 0, 0, 3);  hold(3, 1, 0, 10); hold(3, 0, 0, 10);
      hold(3, 1, 0, 10); hold(3, 0, 0, 10);
      check("t1.state", int'(bus.state_led), 3);
      check("t1.disp",  int'(bus.disp_num),  9);
      check("t1.a",     int'(bus.mult_a),    3);

      // back to GET_A, then a bouncing ENTER
      hold(0, 1, 0, 10); hold(0, 0, 0, 10);
      check("t2.pre", int'(bus.state_led), 0);
      hold(1, 1, 0, 2); hold(1, 0, 0, 2); hold(1, 1, 0, 2); hold(1, 0, 0, 2);
      hold(1, 1, 0, 10); hold(1, 0, 0, 10);
      check("t2.state", int'(bus.state_led), 1);
      check("t2.a",     int'(bus.mult_a),    1);

      // clear and enter together in GET_B with A=2
      hold(2, 0, 1, 10); hold(2, 0, 0, 10);
      hold(2, 1, 0, 10); hold(2, 0, 0, 10);
      check("t3.pre_a", int'(bus.mult_a), 2);
      hold(1, 1, 1, 10); hold(1, 0, 0, 10);
      check("t3.state", int'(bus.state_led), 0);
      check("t3.a",     int'(bus.mult_a),    0);
      check("t3.disp",  int'(bus.disp_num),  1);

      // switches alone in GET_A
      hold(0, 0, 0, 4); hold(1, 0, 0, 4); hold(2, 0, 0, 4);
      check("t4.disp", int'(bus.disp_num), 2);
      check("t4.a",    int'(bus.mult_a),   0);

      // 2 x 1, then sw ignored in SHOW
      hold(2, 1, 0, 10); hold(2, 0, 0, 10);
      hold(1, 1, 0, 10); hold(1, 0, 0, 10);
      check("t5.show", int'(bus.disp_num), 2);
      hold(3, 0, 0, 6);
      check("t5.hold", int'(bus.disp_num), 2);
      hold(3, 1, 0, 10); hold(3, 0, 0, 10);
      check("t5.state", int'(bus.state_led), 0);
      check("t5.disp",  int'(bus.disp_num),  3);

      // reset while ENTER held in GET_B
      hold(1, 1, 0, 10); hold(1, 0, 0, 10);
      check("t6.pre", int'(bus.state_led), 1);
      hold(1, 1, 0, 3);
      async_reset();
      hold(1, 1, 0, 20);
      check("t6.held", int'(bus.state_led), 0);
      hold(1, 0, 0, 10);
      hold(1, 1, 0, 10); hold(1, 0, 0, 10);
      check("t6.again", int'(bus.state_led), 1);

      // randomized traffic
      for (int seg = 0; seg < 300; seg++) begin
         seg_len = $urandom_range(1, 12);
         seg_sw  = $urandom_range(0, 3);
         seg_en  = ($urandom_range(0, 2) == 0) ? 1 : 0;
         seg_cl  = ($urandom_range(0, 11) == 0) ? 1 : 0;
         hold(seg_sw, seg_en, seg_cl, seg_len);
         if ($urandom_range(0, 59) == 0) async_reset();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
